// File: rtl/ifm_out_fsm.sv
// Drains the per-frame status FIFO and the data FIFO of the MAC receive path.
// Good frames go out as AXI4-Stream; bad or disabled frames are dropped. Frame and byte counters are kept.
module ifm_out_fsm #(
   parameter int C_CNT_W      = 32,
   parameter int C_BYTE_CNT_W = 48
) (
   input  logic                    rx_clk,
   input  logic                    rx_reset,
   input  logic [72:0]             data_fifo_rdata,
   input  logic                    data_fifo_empty,
   output logic                    data_fifo_rden,
   input  logic [7:0]              info_fifo_rdata,
   input  logic                    info_fifo_empty,
   output logic                    info_fifo_rden,
   input  logic                    fwd_enable,
   output logic [63:0]             m_axis_tdata,
   output logic [7:0]              m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [C_CNT_W-1:0]      good_frame_cnt,
   output logic [C_CNT_W-1:0]      bad_frame_cnt,
   output logic [C_CNT_W-1:0]      dis_frame_cnt,
   output logic [C_BYTE_CNT_W-1:0] good_byte_cnt,
   output logic [3:0]              ifm_out_fsm_dbg
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FWD  = 2'd1,
      S_DISC = 2'd2,
      S_ILL  = 2'd3
   } state_t;

   state_t                  state_q, state_d;
   logic [C_CNT_W-1:0]      good_q, good_d;
   logic [C_CNT_W-1:0]      bad_q, bad_d;
   logic [C_CNT_W-1:0]      dis_q, dis_d;
   logic [C_BYTE_CNT_W-1:0] bytes_q, bytes_d;
   logic [3:0]              keep_cnt;
   logic                    head_last;

   assign head_last    = data_fifo_rdata[72];
   assign m_axis_tdata = data_fifo_rdata[63:0];
   assign m_axis_tkeep = data_fifo_rdata[71:64];

   always_comb begin
      keep_cnt = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         keep_cnt = keep_cnt + 4'(data_fifo_rdata[64+i]);
      end
   end

   always_ff @(posedge rx_clk or posedge rx_reset) begin
      if (rx_reset) begin
         state_q <= S_IDLE;
         good_q  <= '0;
         bad_q   <= '0;
         dis_q   <= '0;
         bytes_q <= '0;
      end else begin
         state_q <= state_d;
         good_q  <= good_d;
         bad_q   <= bad_d;
         dis_q   <= dis_d;
         bytes_q <= bytes_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      good_d         = good_q;
      bad_d          = bad_q;
      dis_d          = dis_q;
      bytes_d        = bytes_q;
      info_fifo_rden = 1'b0;
      data_fifo_rden = 1'b0;
      m_axis_tvalid  = 1'b0;
      m_axis_tlast   = 1'b0;
      case (state_q)
         S_IDLE: begin
            // fwd_enable is only looked at here, so a frame's fate is fixed at its status pop
            info_fifo_rden = ~info_fifo_empty;
            if (!info_fifo_empty) begin
               if (info_fifo_rdata[0]) begin
                  state_d = S_DISC;
                  bad_d   = bad_q + C_CNT_W'(1);
               end else if (fwd_enable) begin
                  state_d = S_FWD;
               end else begin
                  state_d = S_DISC;
                  dis_d   = dis_q + C_CNT_W'(1);
               end
            end
         end
         S_FWD: begin
            m_axis_tvalid  = ~data_fifo_empty;
            m_axis_tlast   = ~data_fifo_empty & head_last;
            data_fifo_rden = ~data_fifo_empty & m_axis_tready;
            if (data_fifo_rden) begin
               bytes_d = bytes_q + C_BYTE_CNT_W'(keep_cnt);
               if (head_last) begin
                  good_d  = good_q + C_CNT_W'(1);
                  state_d = S_IDLE;
               end
            end
         end
         S_DISC: begin
            data_fifo_rden = ~data_fifo_empty;
            if (!data_fifo_empty && head_last) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign good_frame_cnt  = good_q;
   assign bad_frame_cnt   = bad_q;
   assign dis_frame_cnt   = dis_q;
   assign good_byte_cnt   = bytes_q;
   assign ifm_out_fsm_dbg = {2'b00, state_q};

endmodule

// File: tb/tb_ifm_out_fsm.sv
// Bench for ifm_out_fsm: FWFT FIFOs modelled as queues, frame-level reference model and scoreboard.
module tb_ifm_out_fsm;
   localparam int CW = 32;
   localparam int BW = 48;

   logic          rx_clk = 1'b0;
   logic          rx_reset;
   logic [72:0]   data_fifo_rdata;
   logic          data_fifo_empty;
   logic          data_fifo_rden;
   logic [7:0]    info_fifo_rdata;
   logic          info_fifo_empty;
   logic          info_fifo_rden;
   logic          fwd_enable;
   logic [63:0]   m_axis_tdata;
   logic [7:0]    m_axis_tkeep;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [CW-1:0] good_frame_cnt, bad_frame_cnt, dis_frame_cnt;
   logic [BW-1:0] good_byte_cnt;
   logic [3:0]    ifm_out_fsm_dbg;

   always #5 rx_clk = ~rx_clk;

   ifm_out_fsm #(.C_CNT_W(CW), .C_BYTE_CNT_W(BW)) dut (
      .rx_clk(rx_clk), .rx_reset(rx_reset),
      .data_fifo_rdata(data_fifo_rdata), .data_fifo_empty(data_fifo_empty), .data_fifo_rden(data_fifo_rden),
      .info_fifo_rdata(info_fifo_rdata), .info_fifo_empty(info_fifo_empty), .info_fifo_rden(info_fifo_rden),
      .fwd_enable(fwd_enable),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .good_frame_cnt(good_frame_cnt), .bad_frame_cnt(bad_frame_cnt), .dis_frame_cnt(dis_frame_cnt),
      .good_byte_cnt(good_byte_cnt), .ifm_out_fsm_dbg(ifm_out_fsm_dbg)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      int          kind;   // 0 data word, 1 status entry, 2 idle cycle
      logic [72:0] w;
      logic [7:0]  s;
   } item_t;

   logic [72:0] dq[$];
   logic [7:0]  iq[$];
   item_t       prod[$];
   logic [72:0] allw[$];
   int          flen[$];
   logic [72:0] exp_q[$];
   bit          rdy_scr[$];

   int  rem = 0;
   bit  fwd_frame = 0;
   logic [CW-1:0] m_good, m_bad, m_dis;
   logic [BW-1:0] m_bytes;
   int  prod_pct = 100, rdy_pct = 100, stall_cnt = 0;
   bit  fwd_rand = 0, fwd_val = 1, d_empty = 1;

   task automatic add_frame(input int n, input bit bad, input logic [7:0] lastk, input bit direct);
      logic [72:0] w;
      logic [7:0]  s;
      for (int b = 0; b < n; b++) begin
         w = {b == n - 1, (b == n - 1) ? lastk : 8'hFF, $urandom(), $urandom()};
         allw.push_back(w);
         if (direct) dq.push_back(w);
         else prod.push_back('{0, w, 8'h00});
      end
      s = {7'($urandom()), bad};
      if (direct) iq.push_back(s);
      else prod.push_back('{1, 73'h0, s});
      flen.push_back(n);
   endtask

   // Frame-level model: a frame's length is known from the generator, so the end of a
   // frame is found by counting remaining words rather than by looking at tlast.
   task automatic model_step();
      bit e_info, e_drd, e_tv;
      logic [72:0] w;
      logic [7:0]  s;
      int n;
      e_info = 0; e_drd = 0; e_tv = 0;
      if (rem == 0) e_info = (iq.size() != 0);
      else if (fwd_frame) begin
         e_tv  = !d_empty;
         e_drd = e_tv && m_axis_tready;
      end else e_drd = !d_empty;

      chk("info_rden", info_fifo_rden, e_info);
      chk("data_rden", data_fifo_rden, e_drd);
      chk("tvalid", m_axis_tvalid, e_tv);
      chk("dbg", ifm_out_fsm_dbg, (rem == 0) ? 4'd0 : (fwd_frame ? 4'd1 : 4'd2));
      chk("good_cnt", good_frame_cnt, m_good);
      chk("bad_cnt", bad_frame_cnt, m_bad);
      chk("dis_cnt", dis_frame_cnt, m_dis);
      chk("byte_cnt", good_byte_cnt, m_bytes);
      if (e_tv) chk("beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q[0]);

      if (e_info) begin
         s = iq.pop_front();
         n = flen.pop_front();
         rem = n;
         if (s[0]) begin fwd_frame = 0; m_bad++; end
         else if (fwd_enable) fwd_frame = 1;
         else begin fwd_frame = 0; m_dis++; end
         for (int i = 0; i < n; i++) begin
            w = allw.pop_front();
            if (fwd_frame) exp_q.push_back(w);
         end
      end else if (e_drd) begin
         w = dq.pop_front();
         rem--;
         if (fwd_frame) begin
            void'(exp_q.pop_front());
            m_bytes += BW'($countones(w[71:64]));
            if (rem == 0) m_good++;
         end
      end
   endtask

   task automatic cycle();
      item_t it;
      @(negedge rx_clk);
      if (prod.size() != 0 && $urandom_range(99) < prod_pct) begin
         it = prod.pop_front();
         if (it.kind == 0) dq.push_back(it.w);
         else if (it.kind == 1) iq.push_back(it.s);
      end
      if (rdy_scr.size() != 0) m_axis_tready = rdy_scr.pop_front();
      else m_axis_tready = ($urandom_range(99) < rdy_pct);
      fwd_enable = fwd_rand ? 1'($urandom_range(1)) : fwd_val;
      if (stall_cnt > 0) begin stall_cnt--; d_empty = 1; end
      else d_empty = (dq.size() == 0);
      data_fifo_empty = d_empty;
      data_fifo_rdata = (dq.size() != 0) ? dq[0] : {$urandom(), $urandom(), $urandom()};
      info_fifo_empty = (iq.size() == 0);
      info_fifo_rdata = (iq.size() != 0) ? iq[0] : 8'($urandom());
      #1;
      model_step();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic do_reset();
      #2;
      rx_reset = 1'b1;
      dq.delete(); iq.delete(); prod.delete(); allw.delete(); flen.delete();
      exp_q.delete(); rdy_scr.delete();
      rem = 0; fwd_frame = 0; stall_cnt = 0;
      m_good = '0; m_bad = '0; m_dis = '0; m_bytes = '0;
      data_fifo_empty = 1'b1;
      info_fifo_empty = 1'b1;
      #1;
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_tlast", m_axis_tlast, 0);
      chk("rst_info_rden", info_fifo_rden, 0);
      chk("rst_data_rden", data_fifo_rden, 0);
      chk("rst_dbg", ifm_out_fsm_dbg, 0);
      chk("rst_cnts", {good_frame_cnt, bad_frame_cnt}, 0);
      chk("rst_dis_bytes", {dis_frame_cnt, good_byte_cnt}, 0);
      @(negedge rx_clk);
      rx_reset = 1'b0;
   endtask

   initial begin
      int cyc;
      rx_reset = 1'b1;
      data_fifo_rdata = '0; data_fifo_empty = 1'b1;
      info_fifo_rdata = '0; info_fifo_empty = 1'b1;
      fwd_enable = 1'b1; m_axis_tready = 1'b1;
      do_reset();

      // good 3-beat frame: 8+8+4 bytes
      add_frame(3, 0, 8'h0F, 1);
      run(6);
      chk("t1_good", good_frame_cnt, 1);
      chk("t1_bytes", good_byte_cnt, 20);

      do_reset();
      add_frame(4, 1, 8'hFF, 1);
      run(7);
      chk("t2_bad", bad_frame_cnt, 1);
      chk("t2_good_bytes", {good_frame_cnt, good_byte_cnt}, 0);

      // backpressure 1,0,0,1,1 on the beats (first entry covers the status pop)
      do_reset();
      add_frame(3, 0, 8'h3F, 1);
      rdy_scr = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      run(9);
      chk("t3_good", good_frame_cnt, 1);
      chk("t3_bytes", good_byte_cnt, 22);

      // frame A while disabled, frame B enabled with fwd_enable toggling mid-frame
      do_reset();
      add_frame(3, 0, 8'hFF, 1);
      add_frame(4, 0, 8'h01, 1);
      fwd_val = 0;
      run(1);
      fwd_val = 1;
      run(4);
      fwd_rand = 1;
      run(8);
      fwd_rand = 0;
      chk("t4_dis", dis_frame_cnt, 1);
      chk("t4_good", good_frame_cnt, 1);
      chk("t4_bytes", good_byte_cnt, 25);

      // data underrun between beats 2 and 3
      do_reset();
      add_frame(4, 0, 8'hFF, 1);
      run(3);
      stall_cnt = 5;
      run(12);
      chk("t5_good", good_frame_cnt, 1);
      chk("t5_bytes", good_byte_cnt, 32);

      // reset while beat 2 is presented, then a normal frame
      do_reset();
      add_frame(4, 0, 8'hFF, 1);
      run(3);
      do_reset();
      add_frame(3, 0, 8'h07, 1);
      run(6);
      chk("t6_good", good_frame_cnt, 1);
      chk("t6_bytes", good_byte_cnt, 19);

      // randomized traffic
      do_reset();
      prod_pct = 60; rdy_pct = 70; fwd_rand = 1;
      for (int f = 0; f < 40; f++)
         add_frame($urandom_range(9, 2), $urandom_range(3) == 0, 8'hFF >> $urandom_range(7), 0);
      cyc = 0;
      while ((prod.size() != 0 || flen.size() != 0 || rem != 0) && cyc < 5000) begin
         if ($urandom_range(49) == 0 && stall_cnt == 0) stall_cnt = $urandom_range(3, 1);
         cycle();
         cyc++;
      end
      chk("rand_drained", flen.size() + rem, 0);
      run(2);
      chk("rand_total", good_frame_cnt + bad_frame_cnt + dis_frame_cnt, 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
